// File: rtl/bip_pkg.sv
// Shared opcode, FSM-state, decode-class and mult_A select definitions for the BIP control unit.
// Pure declarations; no logic or timing of its own.
package bip_pkg;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SELA_DATA   = 2'b00;
  localparam logic [1:0] SELA_SIGNAL = 2'b01;
  localparam logic [1:0] SELA_ARIT   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEMWAIT,
    ST_EXEC,
    ST_HALT
  } state_e;

  // Where DECODE sends the FSM for a given opcode.
  typedef enum logic [1:0] {
    CLS_MEM,
    CLS_EXEC,
    CLS_HALT,
    CLS_ILLEGAL
  } cls_e;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       wr_ram;
  } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: opcode -> next-state class and EXEC-cycle control vector.
// Purely combinational (zero latency); no flow control.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opc_i,
  output cls_e             cls_o,
  output ctrl_t            ctrl_o
);

  always_comb begin
    cls_o  = CLS_ILLEGAL;
    ctrl_o = '0;
    case (opc_i)
      OPC_W'(OPC_HLT): cls_o = CLS_HALT;
      OPC_W'(OPC_STO): begin
        cls_o         = CLS_EXEC;
        ctrl_o.wr_ram = 1'b1;
      end
      OPC_W'(OPC_LD): begin
        cls_o         = CLS_MEM;
        ctrl_o.sel_a  = SELA_DATA;
        ctrl_o.wr_acc = 1'b1;
      end
      OPC_W'(OPC_LDI): begin
        cls_o         = CLS_EXEC;
        ctrl_o.sel_a  = SELA_SIGNAL;
        ctrl_o.wr_acc = 1'b1;
      end
      OPC_W'(OPC_ADD): begin
        cls_o         = CLS_MEM;
        ctrl_o.sel_a  = SELA_ARIT;
        ctrl_o.wr_acc = 1'b1;
      end
      OPC_W'(OPC_ADDI): begin
        cls_o         = CLS_EXEC;
        ctrl_o.sel_a  = SELA_ARIT;
        ctrl_o.sel_b  = 1'b1;
        ctrl_o.wr_acc = 1'b1;
      end
      OPC_W'(OPC_SUB): begin
        cls_o         = CLS_MEM;
        ctrl_o.sel_a  = SELA_ARIT;
        ctrl_o.op     = 1'b1;
        ctrl_o.wr_acc = 1'b1;
      end
      OPC_W'(OPC_SUBI): begin
        cls_o         = CLS_EXEC;
        ctrl_o.sel_a  = SELA_ARIT;
        ctrl_o.sel_b  = 1'b1;
        ctrl_o.op     = 1'b1;
        ctrl_o.wr_acc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// bip_control: BIP multi-cycle sequencer (IDLE/FETCH/DECODE/MEMWAIT/EXEC/HALT); outputs decode from registered state and IR.
// Stalls in MEMWAIT until i_mem_ready or MEM_TIMEOUT cycles (then faults); BIP_ILLEGAL_TRAP_EN makes illegal opcodes fault.
module bip_control
  import bip_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int OPC_W       = 5,
  parameter int ADDR_W      = 11,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic [DATA_W-1:0] i_instr,
  input  logic              i_mem_ready,
  output logic              o_pc_en,
  output logic [1:0]        o_selA,
  output logic              o_selB,
  output logic              o_op,
  output logic              o_wrAcc,
  output logic              o_rdRAM,
  output logic              o_wrRAM,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_signal,
  output logic              o_halt,
  output logic              o_fault
);

  localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fault_q, fault_d;

  cls_e  dec_cls;
  ctrl_t dec_ctrl;

  bip_decoder #(
    .OPC_W (OPC_W)
  ) u_decoder (
    .opc_i  (ir_q[DATA_W-1 -: OPC_W]),
    .cls_o  (dec_cls),
    .ctrl_o (dec_ctrl)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = '0;
    fault_d = fault_q;
    o_pc_en = 1'b0;
    o_selA  = SELA_DATA;
    o_selB  = 1'b0;
    o_op    = 1'b0;
    o_wrAcc = 1'b0;
    o_rdRAM = 1'b0;
    o_wrRAM = 1'b0;
    o_halt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = i_instr;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (dec_cls)
          CLS_MEM:  state_d = ST_MEMWAIT;
          CLS_EXEC: state_d = ST_EXEC;
          CLS_HALT: state_d = ST_HALT;
          default: begin
`ifdef BIP_ILLEGAL_TRAP_EN
            state_d = ST_HALT;
            fault_d = 1'b1;
`else
            state_d = ST_EXEC;
`endif
          end
        endcase
      end
      ST_MEMWAIT: begin
        o_rdRAM = 1'b1;
        // A ready arriving on the final allowed cycle still wins over the timeout.
        if (i_mem_ready) begin
          state_d = ST_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_EXEC: begin
        o_pc_en = 1'b1;
        o_selA  = dec_ctrl.sel_a;
        o_selB  = dec_ctrl.sel_b;
        o_op    = dec_ctrl.op;
        o_wrAcc = dec_ctrl.wr_acc;
        o_wrRAM = dec_ctrl.wr_ram;
        state_d = i_run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        o_halt = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_addr   = ir_q[ADDR_W-1:0];
  assign o_signal = {{(DATA_W-ADDR_W){ir_q[ADDR_W-1]}}, ir_q[ADDR_W-1:0]};
  assign o_fault  = fault_q;

endmodule
